// File: rtl/mux3_8.sv
// mux3_8: registered three-channel selector with a sticky illegal-select flag.
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous, active-high; clears every output
//   Habilita   - capture enable; 0 holds all state
//   Entrada0-2 - WIDTH-bit data channels
//   Controle   - channel select (00/01/10), 11 is illegal
//   Resultado  - registered selected data (zero after an illegal select)
//   Valido     - registered; 1 when Resultado came from a legal select
//   Erro       - registered sticky flag; set by an enabled illegal select
module mux3_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Habilita,
    input  logic [WIDTH-1:0] Entrada0,
    input  logic [WIDTH-1:0] Entrada1,
    input  logic [WIDTH-1:0] Entrada2,
    input  logic [1:0]       Controle,
    output logic [WIDTH-1:0] Resultado,
    output logic             Valido,
    output logic             Erro
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;

    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        unique case (1'b1)
            (Controle == 2'b00): begin
                sel_data = Entrada0;
                sel_ok   = 1'b1;
            end
            (Controle == 2'b01): begin
                sel_data = Entrada1;
                sel_ok   = 1'b1;
            end
            (Controle == 2'b10): begin
                sel_data = Entrada2;
                sel_ok   = 1'b1;
            end
            (Controle == 2'b11): begin
                sel_data = '0;
                sel_ok   = 1'b0;
            end
        endcase
    end

    // Erro only ever sets here; clearing it is reset's job alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            Resultado <= '0;
            Valido    <= 1'b0;
            Erro      <= 1'b0;
        end else if (Habilita) begin
            Resultado <= sel_data;
            Valido    <= sel_ok;
            if (!sel_ok) begin
                Erro <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux3_8.sv
// tb_mux3_8: directed and randomized checks of mux3_8 against a
// channel-array reference model.
module tb_mux3_8;

    localparam int WIDTH = 8;

    logic             clock    = 1'b0;
    logic             reset    = 1'b1;
    logic             Habilita = 1'b0;
    logic [WIDTH-1:0] Entrada0 = '0;
    logic [WIDTH-1:0] Entrada1 = '0;
    logic [WIDTH-1:0] Entrada2 = '0;
    logic [1:0]       Controle = 2'b00;
    logic [WIDTH-1:0] Resultado;
    logic             Valido;
    logic             Erro;

    int tests = 0;
    int fails = 0;

    int exp_res = 0;
    int exp_val = 0;
    int exp_err = 0;

    mux3_8 #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .Habilita  (Habilita),
        .Entrada0  (Entrada0),
        .Entrada1  (Entrada1),
        .Entrada2  (Entrada2),
        .Controle  (Controle),
        .Resultado (Resultado),
        .Valido    (Valido),
        .Erro      (Erro)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".res"}, int'(Resultado), exp_res);
        check({tag, ".val"}, int'(Valido), exp_val);
        check({tag, ".err"}, int'(Erro), exp_err);
    endtask

    // Reference: the three channels as an array, indexed by the select.
    task automatic model(input logic r, input logic h,
                         input int ch[3], input int c);
        if (r) begin
            exp_res = 0;
            exp_val = 0;
            exp_err = 0;
        end else if (h) begin
            if (c == 3) begin
                exp_res = 0;
                exp_val = 0;
                exp_err = 1;
            end else begin
                exp_res = ch[c];
                exp_val = 1;
            end
        end
    endtask

    // Inputs change just after a rising edge; outputs are checked again at
    // the falling edge (must not have moved) and just after the next edge.
    task automatic step(input string tag, input logic r, input logic h,
                        input logic [WIDTH-1:0] e0,
                        input logic [WIDTH-1:0] e1,
                        input logic [WIDTH-1:0] e2,
                        input logic [1:0] c);
        int ch[3];
        reset    = r;
        Habilita = h;
        Entrada0 = e0;
        Entrada1 = e1;
        Entrada2 = e2;
        Controle = c;
        ch[0] = int'(e0);
        ch[1] = int'(e1);
        ch[2] = int'(e2);
        @(negedge clock);
        check_all({tag, ".mid"});
        @(posedge clock);
        model(r, h, ch, int'(c));
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] c;
        @(posedge clock);
        #1;

        step("rst1", 1, 0, 8'h00, 8'h00, 8'h00, 2'b00);
        step("rst2", 1, 1, 8'h12, 8'h34, 8'h56, 2'b11);

        step("cyc00", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b00);
        step("cyc01", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b01);
        step("cyc10", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b10);
        step("cyc00b", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b00);

        step("ill11", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b11);
        step("ill01", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b01);
        step("ill00", 0, 1, 8'hFF, 8'h55, 8'h00, 2'b00);

        step("hld_ld", 0, 1, 8'h00, 8'h55, 8'h00, 2'b01);
        step("hld1", 0, 0, 8'hAA, 8'h0F, 8'hF0, 2'b11);
        step("hld2", 0, 0, 8'h3C, 8'hC3, 8'h99, 2'b00);
        step("hld3", 0, 0, 8'hFF, 8'h00, 8'h77, 2'b10);
        step("hld4", 0, 0, 8'h01, 8'h80, 8'hEE, 2'b11);

        step("rstpri", 1, 1, 8'hFF, 8'h00, 8'h00, 2'b00);
        step("post", 0, 1, 8'h00, 8'h00, 8'h6B, 2'b10);

        for (int i = 0; i < 6; i++) begin
            step("iso", 0, 1, (i % 2) ? 8'hFF : 8'h00,
                 (i % 2) ? 8'h00 : 8'hFF, 8'hA5, 2'b10);
        end

        for (int i = 0; i < 400; i++) begin
            c = 2'($urandom_range(0, 3));
            step("rnd", ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), 8'($urandom), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux3_8.md
MUX3_8 -- requirements
Module: mux3_8

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every data input and of Resultado.
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port Habilita  input  1  capture enable; 1 = load the selected input this edge, 0 = hold all state.
REQ-005 Port Entrada0  input  WIDTH  data channel 0.
REQ-006 Port Entrada1  input  WIDTH  data channel 1.
REQ-007 Port Entrada2  input  WIDTH  data channel 2.
REQ-008 Port Controle  input  2  channel select: 00 -> Entrada0, 01 -> Entrada1, 10 -> Entrada2, 11 -> illegal.
REQ-009 Port Resultado  output  WIDTH  registered selected data.
REQ-010 Port Valido  output  1  registered; 1 = Resultado holds a legally selected value.
REQ-011 Port Erro  output  1  registered sticky flag; 1 = Controle=11 was sampled with Habilita=1 since the last reset.
REQ-012 Port order SHALL be clock, reset, Habilita, Entrada0, Entrada1, Entrada2, Controle, Resultado, Valido, Erro.

Function
REQ-013 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-014 Latency SHALL be exactly one clock: Resultado after edge N reflects Entrada*/Controle sampled at edge N.
REQ-015 With reset=0, Habilita=1 and Controle=00, 01 or 10, the block SHALL load Resultado with Entrada0, Entrada1 or Entrada2 respectively and set Valido=1.
REQ-016 With reset=0, Habilita=1 and Controle=11, the block SHALL load Resultado with all zeros, set Valido=0 and set Erro=1.
REQ-017 Once set, Erro SHALL remain 1 until reset, regardless of later legal selections.
REQ-018 With reset=0 and Habilita=0, Resultado, Valido and Erro SHALL hold their previous values, whatever Controle is, including 11.
REQ-019 Data SHALL pass bit-exact, with no inversion, reordering or width change; all WIDTH bits SHALL be selected together from one channel.
REQ-020 Changes on unselected channels SHALL NOT affect any output.
REQ-021 Any change of Controle between edges SHALL take effect at the next edge only.
REQ-022 Consecutive enabled cycles SHALL each load independently, with no pipelining beyond one register stage and no back-pressure.

Reset
REQ-023 When reset=1 at a rising edge, the block SHALL set Resultado=0, Valido=0 and Erro=0.
REQ-024 Reset SHALL override Habilita and Controle on the same edge.
REQ-025 Reset asserted mid-stream SHALL take effect at that edge with no residual state, and the first enabled edge after reset release SHALL load normally.
REQ-026 Reset SHALL have no asynchronous effect: outputs SHALL NOT change between clock edges.

Verification
REQ-027 Reset sequence: reset=1 for 2 edges, then release -> Resultado=00000000, Valido=0, Erro=0.
REQ-028 Select cycling: Entrada0=11111111, Entrada1=01010101, Entrada2=00000000, Habilita=1, Controle cycled 00,01,10,00 on successive edges -> Resultado one edge later is 11111111, 01010101, 00000000, 11111111, with Valido=1 throughout.
REQ-029 Illegal select: Controle=11 with Habilita=1 -> next edge Resultado=00000000, Valido=0, Erro=1; then Controle=01 -> Resultado=01010101, Valido=1, Erro stays 1 until reset.
REQ-030 Hold: load 01010101, then Habilita=0 while Controle and all Entrada* toggle, including Controle=11 -> Resultado stays 01010101, Valido=1, Erro unchanged.
REQ-031 Reset priority: reset=1, Habilita=1, Controle=00 with Entrada0=11111111 on the same edge -> Resultado=00000000, Valido=0, Erro=0.
REQ-032 Isolation: Controle=10, then toggle Entrada0 and Entrada1 every cycle while Entrada2=10100101 -> Resultado constant at 10100101.
